// File: rtl/hazard_pkg.sv
// Shared types and helpers for the ID-stage hazard scoreboard.
package hazard_pkg;

  // Producer class of the instruction in ID; 2'b11 is handled as ALU.
  typedef enum logic [1:0] {
    CLS_ALU  = 2'd0,
    CLS_LOAD = 2'd1,
    CLS_LONG = 2'd2
  } op_class_e;

  // All-ones counter value marks a register owned by the long unit.
  function automatic int unsigned long_mark(input int unsigned lat_w);
    return (32'd1 << lat_w) - 32'd1;
  endfunction

endpackage

// File: rtl/hazard_reg_timer.sv
// One register's countdown until its in-flight result can be forwarded.
module hazard_reg_timer
  import hazard_pkg::*;
#(
  parameter int LAT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_en_i,
  input  logic [LAT_W-1:0] load_val_i,
  input  logic             done_hit_i,
  output logic [LAT_W-1:0] cnt_o,
  output logic             busy_o,
  output logic             is_long_o
);

  localparam logic [LAT_W-1:0] LONG_MARK = LAT_W'(long_mark(LAT_W));

  logic [LAT_W-1:0] cnt_q, cnt_d;

  assign cnt_o     = cnt_q;
  assign busy_o    = (cnt_q != '0);
  assign is_long_o = (cnt_q == LONG_MARK);

  // Next count: new issue wins, then long completion, then plain countdown.
  always_comb begin
    cnt_d = cnt_q;
    if (load_en_i)
      cnt_d = load_val_i;
    else if (done_hit_i && is_long_o)
      cnt_d = LAT_W'(1);
    else if (busy_o && !is_long_o)
      cnt_d = cnt_q - LAT_W'(1);
  end

  // Counter register, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Scoreboard-based hazard detection beside ID: per-register timers,
// source/WAW/structural compares, stall OR tree and a stall-cycle counter.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_NUM  = 32,
  parameter int REG_AW   = 5,
  parameter int LAT_W    = 3,
  parameter int LAT_ALU  = 1,
  parameter int LAT_LOAD = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic [REG_AW-1:0]  id_rs1,
  input  logic [REG_AW-1:0]  id_rs2,
  input  logic               id_use_rs1,
  input  logic               id_use_rs2,
  input  logic               id_is_branch,
  input  logic               id_wen,
  input  logic [REG_AW-1:0]  id_rd,
  input  logic [1:0]         id_class,
  input  logic               flush,
  input  logic               long_done,
  input  logic [REG_AW-1:0]  long_rd,
  input  logic               perf_clr,
  output logic               stall,
  output logic [REG_NUM-1:0] busy_vec,
  output logic               long_busy,
  output logic [31:0]        stall_cnt
);

  localparam logic [LAT_W-1:0] LONG_MARK = LAT_W'(long_mark(LAT_W));

  logic [REG_NUM-1:0][LAT_W-1:0] cnt;
  logic [REG_NUM-1:0]            is_long_vec;
  logic [LAT_W-1:0]              load_val;
  logic                          haz_rs1, haz_rs2, haz_waw, haz_struct;
  logic                          issue;
  logic [31:0]                   stall_cnt_q, stall_cnt_d;

  // x0 never holds a pending result.
  assign cnt[0]         = '0;
  assign busy_vec[0]    = 1'b0;
  assign is_long_vec[0] = 1'b0;

  for (genvar r = 1; r < REG_NUM; r++) begin : g_tmr
    hazard_reg_timer #(.LAT_W(LAT_W)) u_tmr (
      .clk        (clk),
      .rst        (rst),
      .load_en_i  (issue && (id_rd == REG_AW'(r))),
      .load_val_i (load_val),
      .done_hit_i (long_done && (long_rd == REG_AW'(r))),
      .cnt_o      (cnt[r]),
      .busy_o     (busy_vec[r]),
      .is_long_o  (is_long_vec[r])
    );
  end

  assign long_busy = |is_long_vec;

  // A branch needs the value in ID, one cycle earlier than an EX consumer.
  function automatic logic src_hazard(input logic use_rs, input logic nz,
                                      input logic [LAT_W-1:0] c, input logic br);
    logic pend;
    pend = (c == LONG_MARK) || (br ? (c > LAT_W'(0)) : (c > LAT_W'(1)));
    return use_rs && nz && pend;
  endfunction

  // Hazard compares, stall tree and issue qualification.
  always_comb begin
    haz_rs1    = src_hazard(id_use_rs1, id_rs1 != '0, cnt[id_rs1], id_is_branch);
    haz_rs2    = src_hazard(id_use_rs2, id_rs2 != '0, cnt[id_rs2], id_is_branch);
    haz_waw    = id_wen && (id_rd != '0) && (cnt[id_rd] == LONG_MARK);
    haz_struct = (id_class == CLS_LONG) && long_busy;
    stall      = !rst && id_valid && !flush &&
                 (haz_rs1 || haz_rs2 || haz_waw || haz_struct);
    issue      = id_valid && !flush && !stall && id_wen && (id_rd != '0);
  end

  // Countdown value loaded by the destination register on issue.
  always_comb begin
    load_val = LAT_W'(LAT_ALU);
    if (id_class == CLS_LOAD)      load_val = LAT_W'(LAT_LOAD);
    else if (id_class == CLS_LONG) load_val = LONG_MARK;
  end

  // Saturating stall-cycle counter; clear beats increment.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (perf_clr)
      stall_cnt_d = '0;
    else if (stall && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  // Performance counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;

endmodule
